// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one iterative CORDIC cosine core between NUM_REQ requesters.
// Latency: accept T, core_start T+1, core_done T+18, resp_valid T+19 (clk_en held high).
// Backpressure: the result is held in RESP until resp_ready; req_ready stays low until the next IDLE.
//
// Ports: clock/aclr (async active-high)/clk_en; req_valid/req_data/req_ready per requester;
//        resp_valid/resp_id/resp_data/resp_err/resp_ready result channel;
//        core_start/core_dataa/core_result/core_done to the shared CORDIC core.
// Optional watchdog: define CORDIC_SCHED_WATCHDOG_EN to abort a job after WD_LIMIT BUSY cycles
// without core_done (resp_err=1, resp_data=0). Without it resp_err is tied low.
module cordic_sched #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 21,
    parameter int ID_W     = 2,
    parameter int WD_LIMIT = 24
) (
    input  logic                      clock,
    input  logic                      aclr,
    input  logic                      clk_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_err,
    input  logic                      resp_ready,
    output logic                      core_start,
    output logic [DATA_W-1:0]         core_dataa,
    input  logic [DATA_W-1:0]         core_result,
    input  logic                      core_done
);

    localparam int CNT_W = $clog2(WD_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     job_id_q, job_id_d;
    logic [DATA_W-1:0]   dataa_q, dataa_d;
    logic                resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]     resp_id_q, resp_id_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                grant_vld;
    logic [ID_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [DATA_W-1:0]   grant_dat;
    int                  best_dist;
    logic                wd_hit;

`ifdef CORDIC_SCHED_WATCHDOG_EN
    logic resp_err_q, resp_err_d;
    // Counter is 0 in the first BUSY cycle, so WD_LIMIT-1 marks the last allowed BUSY cycle.
    assign wd_hit   = (state_q == BUSY) && (cnt_q == CNT_W'(WD_LIMIT - 1));
    assign resp_err = resp_err_q;
`else
    assign wd_hit   = 1'b0;
    assign resp_err = 1'b0;
`endif

    // Round-robin search: distance 0 is the port right after last_grant, wrapping upward.
    // The smallest distance among valid ports wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        grant_dat = '0;
        best_dist = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] &&
                (((i + NUM_REQ - 1 - int'(last_grant_q)) % NUM_REQ) < best_dist)) begin
                best_dist   = (i + NUM_REQ - 1 - int'(last_grant_q)) % NUM_REQ;
                grant_vld   = 1'b1;
                grant_idx   = ID_W'(i);
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
                grant_dat   = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM state register; every transition needs an enabled cycle.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. core_done outside BUSY is the free-running core and is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = START;
            START:   state_d = BUSY;
            BUSY:    if (core_done || wd_hit) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: strobes exist only on enabled cycles and never while reset is applied.
    always_comb begin
        req_ready  = '0;
        core_start = 1'b0;
        if (clk_en && !aclr) begin
            case (state_q)
                IDLE:    req_ready  = grant_oh;
                START:   core_start = 1'b1;
                default: ;
            endcase
        end
    end

    // Datapath next-state.
    always_comb begin
        last_grant_d = last_grant_q;
        job_id_d     = job_id_q;
        dataa_d      = dataa_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        cnt_d        = cnt_q;
`ifdef CORDIC_SCHED_WATCHDOG_EN
        resp_err_d   = resp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    last_grant_d = grant_idx;
                    job_id_d     = grant_idx;
                    dataa_d      = grant_dat;
                end
            end
            START: cnt_d = '0;
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // A real done wins over a watchdog expiring in the same cycle.
                if (core_done) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = job_id_q;
                    resp_data_d  = core_result;
`ifdef CORDIC_SCHED_WATCHDOG_EN
                    resp_err_d   = 1'b0;
`endif
                end else if (wd_hit) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = job_id_q;
                    resp_data_d  = '0;
`ifdef CORDIC_SCHED_WATCHDOG_EN
                    resp_err_d   = 1'b1;
`endif
                end
            end
            RESP: if (resp_ready) resp_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            job_id_q     <= '0;
            dataa_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            cnt_q        <= '0;
`ifdef CORDIC_SCHED_WATCHDOG_EN
            resp_err_q   <= 1'b0;
`endif
        end else if (clk_en) begin
            last_grant_q <= last_grant_d;
            job_id_q     <= job_id_d;
            dataa_q      <= dataa_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            cnt_q        <= cnt_d;
`ifdef CORDIC_SCHED_WATCHDOG_EN
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign core_dataa = dataa_q;

endmodule
